// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: conditions four raw buttons into press events and runs the
// STOP/RUN/CLEAR FSM that produces the datapath's run level and clear/save/restore pulses.

module stopwatch_cu_btn #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   level;
    logic                   level_q;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], btn};
            level_q <= level;
            // Level only moves after DB_CYCLES consecutive disagreeing samples.
            if (sync_out == level) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                level <= sync_out;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;
endmodule

module stopwatch_cu #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_runstop,
    input  logic       btn_clear,
    input  logic       btn_save,
    input  logic       btn_restore,
    output logic       o_runstop,
    output logic       o_clear,
    output logic       o_save,
    output logic       o_restore,
    output logic [1:0] o_state
);
    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    localparam int B_RUNSTOP = 0;
    localparam int B_CLEAR   = 1;
    localparam int B_SAVE    = 2;
    localparam int B_RESTORE = 3;

    logic [3:0] btn_raw;
    logic [3:0] ev;
    logic [1:0] state;

    assign btn_raw = {btn_restore, btn_save, btn_clear, btn_runstop};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        stopwatch_cu_btn #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .press(ev[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_STOP;
            o_save    <= 1'b0;
            o_restore <= 1'b0;
        end else begin
            o_save    <= 1'b0;
            o_restore <= 1'b0;
            case (state)
                ST_STOP: begin
                    // clear wins outright and swallows a coincident save
                    if (ev[B_CLEAR]) begin
                        state <= ST_CLEAR;
                    end else begin
                        o_save <= ev[B_SAVE];
                        if (ev[B_RESTORE])      o_restore <= 1'b1;
                        else if (ev[B_RUNSTOP]) state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    o_save <= ev[B_SAVE];
                    if (ev[B_RUNSTOP]) state <= ST_STOP;
                end
                default: state <= ST_STOP;
            endcase
        end
    end

    assign o_runstop = (state == ST_RUN);
    assign o_clear   = (state == ST_CLEAR);
    assign o_state   = state;
endmodule

// File: tb/tb_stopwatch_cu.sv
// Randomized and directed bench for stopwatch_cu against a window-based reference model.

module tb_stopwatch_cu;
    localparam int DB   = 4;
    localparam int SYNC = 2;
    localparam int L    = SYNC + DB;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_runstop, btn_clear, btn_save, btn_restore;
    logic       o_runstop, o_clear, o_save, o_restore;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    // reference model: raw sample history per button, debounced level, mode
    logic hist [4][L];
    logic m_lvl [4];
    logic m_prev [4];
    int   m_st;        // 0 stop, 1 run, 2 clear
    logic m_save, m_restore;

    int n_clear, n_save, n_restore, n_rs_rise;
    logic last_rs;

    stopwatch_cu #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_runstop(btn_runstop),
        .btn_clear  (btn_clear),
        .btn_save   (btn_save),
        .btn_restore(btn_restore),
        .o_runstop  (o_runstop),
        .o_clear    (o_clear),
        .o_save     (o_save),
        .o_restore  (o_restore),
        .o_state    (o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < L; j++) hist[b][j] = 1'b0;
            m_lvl[b]  = 1'b0;
            m_prev[b] = 1'b0;
        end
        m_st = 0; m_save = 1'b0; m_restore = 1'b0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step();
        logic raw [4];
        logic ev  [4];
        logic same;
        if (rst) begin
            model_reset();
            return;
        end
        raw[0] = btn_runstop; raw[1] = btn_clear; raw[2] = btn_save; raw[3] = btn_restore;
        for (int b = 0; b < 4; b++) ev[b] = m_lvl[b] && !m_prev[b];
        m_save = 1'b0; m_restore = 1'b0;
        case (m_st)
            0: begin
                if (ev[1]) m_st = 2;
                else begin
                    if (ev[2]) m_save = 1'b1;
                    if (ev[3]) m_restore = 1'b1;
                    else if (ev[0]) m_st = 1;
                end
            end
            1: begin
                if (ev[2]) m_save = 1'b1;
                if (ev[0]) m_st = 0;
            end
            default: m_st = 0;
        endcase
        // level follows the synchronized input once it has held one value for DB samples
        for (int b = 0; b < 4; b++) begin
            for (int j = L - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            m_prev[b] = m_lvl[b];
            same = 1'b1;
            for (int j = SYNC; j < L; j++) if (hist[b][j] != hist[b][SYNC]) same = 1'b0;
            if (same && hist[b][SYNC] != m_lvl[b]) m_lvl[b] = hist[b][SYNC];
        end
    endtask

    task automatic compare_all();
        check("o_runstop", int'(o_runstop), (m_st == 1) ? 1 : 0);
        check("o_clear",   int'(o_clear),   (m_st == 2) ? 1 : 0);
        check("o_state",   int'(o_state),   m_st);
        check("o_save",    int'(o_save),    int'(m_save));
        check("o_restore", int'(o_restore), int'(m_restore));
    endtask

    // Called just after a negedge with inputs settled; returns after the next negedge.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
        n_clear   += int'(o_clear);
        n_save    += int'(o_save);
        n_restore += int'(o_restore);
        if (o_runstop && !last_rs) n_rs_rise++;
        last_rs = o_runstop;
    endtask

    task automatic set_btn(input logic [3:0] m);
        btn_runstop = m[0]; btn_clear = m[1]; btn_save = m[2]; btn_restore = m[3];
    endtask

    task automatic hold(input logic [3:0] m, input int n);
        set_btn(m);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        n_clear = 0; n_save = 0; n_restore = 0; n_rs_rise = 0;
    endtask

    task automatic goto_stop();
        hold(4'b0000, 12);
        if (m_st == 1) begin
            hold(4'b0001, 12);
            hold(4'b0000, 12);
        end
    endtask

    task automatic goto_run();
        goto_stop();
        hold(4'b0001, 12);
        hold(4'b0000, 12);
    endtask

    int hold_left [4];
    logic [3:0] rmask;
    int lat;

    initial begin
        rst = 1'b1;
        set_btn(4'b0000);
        clr_counts();
        last_rs = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick(); tick();
        rst = 1'b0;
        hold(4'b0000, 10);

        // press latency from a clean runstop press
        goto_stop();
        set_btn(4'b0001);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (o_runstop) break;
        end
        check("rs_latency", lat, SYNC + DB + 1);
        hold(4'b0001, 13);
        check("rs_held", int'(o_runstop), 1);
        hold(4'b0000, 12);
        hold(4'b0001, 12);
        check("rs_second_press_state", int'(o_state), 0);
        hold(4'b0000, 12);

        // glitch then bounce: one state change only
        goto_stop();
        clr_counts();
        hold(4'b0001, 3); hold(4'b0000, 6);
        hold(4'b0001, 1); hold(4'b0000, 1); hold(4'b0001, 1); hold(4'b0000, 1);
        hold(4'b0001, 15); hold(4'b0000, 15);
        check("bounce_rises", n_rs_rise, 1);
        check("bounce_state", int'(o_state), 1);

        // clear from STOP, then clear ignored in RUN
        goto_stop();
        clr_counts();
        hold(4'b0010, 12); hold(4'b0000, 12);
        check("clear_stop_pulses", n_clear, 1);
        goto_run();
        clr_counts();
        hold(4'b0010, 12); hold(4'b0000, 12);
        check("clear_run_pulses", n_clear, 0);
        check("clear_run_state", int'(o_state), 1);

        // save/restore in STOP, then in RUN
        goto_stop();
        clr_counts();
        hold(4'b0100, 12); hold(4'b0000, 12);
        hold(4'b1000, 12); hold(4'b0000, 12);
        check("stop_save", n_save, 1);
        check("stop_restore", n_restore, 1);
        goto_run();
        clr_counts();
        hold(4'b1000, 12); hold(4'b0000, 12);
        hold(4'b0100, 12); hold(4'b0000, 12);
        check("run_restore", n_restore, 0);
        check("run_save", n_save, 1);

        // simultaneous clear+restore+runstop from STOP
        goto_stop();
        clr_counts();
        hold(4'b1011, 12); hold(4'b0000, 12);
        check("simul_clear", n_clear, 1);
        check("simul_restore", n_restore, 0);
        check("simul_runstop", int'(o_runstop), 0);
        check("simul_state", int'(o_state), 0);

        // async reset while running
        goto_run();
        #2 rst = 1'b1;
        #1;
        check("async_rst_runstop", int'(o_runstop), 0);
        check("async_rst_state", int'(o_state), 0);
        model_reset();
        tick();
        rst = 1'b0;
        hold(4'b0000, 8);

        // reset asserted in the middle of a press
        goto_stop();
        set_btn(4'b0001);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        hold(4'b0001, 12);
        hold(4'b0000, 12);

        // randomized button activity
        for (int b = 0; b < 4; b++) hold_left[b] = 0;
        rmask = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold_left[b] == 0) begin
                    rmask[b] = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 14);
                end
                hold_left[b]--;
            end
            set_btn(rmask);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        hold(4'b0000, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
